// File: rtl/node_inject_queue_pkg.sv
// Shared types for the node injection queue: packet record, output select enum, widths.
package node_inject_pkg;

   localparam int DROP_CNT_W = 8;
   localparam int STARVE_W   = 8;

   typedef struct packed {
      logic [1:0] typ;
      logic       qos;
      logic [5:0] src;
      logic [5:0] tgt;
      logic [7:0] data;
   } pkt_rec_t;

   localparam int PKT_W = $bits(pkt_rec_t);

   typedef enum logic {
      SEL_HI = 1'b0,
      SEL_LO = 1'b1
   } sel_e;

endpackage

// File: rtl/node_inject_queue_if.sv
// Packet valid/ready channel; used for both the core-side input and the node pkt_in output.
interface node_inject_queue_if;

   logic       vld;
   logic       rdy;
   logic [1:0] typ;
   logic       qos;
   logic [5:0] src;
   logic [5:0] tgt;
   logic [7:0] data;

   modport master (output vld, typ, qos, src, tgt, data, input rdy);
   modport slave  (input vld, typ, qos, src, tgt, data, output rdy);

endinterface

// File: rtl/node_inject_queue_fifo.sv
// Circular-buffer packet FIFO with one extra pointer bit to tell full from empty.
module node_inject_fifo
   import node_inject_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push_i,
   input  logic     pop_i,
   input  pkt_rec_t din_i,
   output logic     full_o,
   output logic     empty_o,
   output pkt_rec_t head_o
);

   localparam int AW = $clog2(DEPTH);

   pkt_rec_t        mem_q [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A push while full is only taken when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/node_inject_queue.sv
// Core-to-mesh injection stage: power-gate drop filter, hi/lo QoS FIFOs, locked output select.
// Optional starvation guard for the lo FIFO is enabled by defining NODE_INJQ_STARVE_GUARD_EN.
module node_inject_queue
   import node_inject_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pg_en_i,
   input  logic [5:0]            pg_node_i,
   node_inject_queue_if.slave    core_i,
   node_inject_queue_if.master   pkt_in_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("node_inject_queue: DEPTH must be a power of 2, at least 2");
   end
   if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_bad_lim
      $error("node_inject_queue: STARVE_LIM must be in 1..255");
   end

   pkt_rec_t                core_rec;
   pkt_rec_t                hi_head, lo_head, out_rec;
   logic                    drop, sel_full;
   logic                    hi_full, hi_empty, lo_full, lo_empty;
   logic                    hi_push, lo_push, hi_pop, lo_pop;
   logic                    out_vld, handshake;
   sel_e                    sel_q, sel_d, sel_cur;
   logic                    lock_q, lock_d;
   logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   assign core_rec = '{typ: core_i.typ, qos: core_i.qos, src: core_i.src,
                       tgt: core_i.tgt, data: core_i.data};

   // Ready is deliberately not gated by valid so the core can see it before asserting valid.
   assign drop        = pg_en_i && (core_i.tgt == pg_node_i);
   assign sel_full    = core_i.qos ? hi_full : lo_full;
   assign core_i.rdy  = drop || !sel_full;
   assign hi_push     = core_i.vld && !drop &&  core_i.qos && !hi_full;
   assign lo_push     = core_i.vld && !drop && !core_i.qos && !lo_full;

   node_inject_fifo #(.DEPTH(DEPTH)) u_hi_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (hi_push),
      .pop_i   (hi_pop),
      .din_i   (core_rec),
      .full_o  (hi_full),
      .empty_o (hi_empty),
      .head_o  (hi_head)
   );

   node_inject_fifo #(.DEPTH(DEPTH)) u_lo_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (lo_push),
      .pop_i   (lo_pop),
      .din_i   (core_rec),
      .full_o  (lo_full),
      .empty_o (lo_empty),
      .head_o  (lo_head)
   );

`ifdef NODE_INJQ_STARVE_GUARD_EN
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                starved;

   assign starved = (starve_q == STARVE_W'(STARVE_LIM));

   always_comb begin
      starve_d = starve_q;
      if (lo_pop)
         starve_d = '0;
      else if (hi_pop && !lo_empty && starve_q != '1)
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   logic starved;
   assign starved = 1'b0;
`endif

   // While locked the stalled packet keeps the output; otherwise hi wins unless lo is starved.
   always_comb begin
      sel_cur = sel_q;
      if (!lock_q) begin
         sel_cur = hi_empty ? SEL_LO : SEL_HI;
         if (starved && !lo_empty) sel_cur = SEL_LO;
      end
   end

   assign out_vld   = (sel_cur == SEL_HI) ? !hi_empty : !lo_empty;
   assign out_rec   = !out_vld ? '0 : ((sel_cur == SEL_HI) ? hi_head : lo_head);
   assign handshake = out_vld && pkt_in_o.rdy;
   assign hi_pop    = handshake && (sel_cur == SEL_HI);
   assign lo_pop    = handshake && (sel_cur == SEL_LO);

   assign pkt_in_o.vld  = out_vld;
   assign pkt_in_o.typ  = out_rec.typ;
   assign pkt_in_o.qos  = out_rec.qos;
   assign pkt_in_o.src  = out_rec.src;
   assign pkt_in_o.tgt  = out_rec.tgt;
   assign pkt_in_o.data = out_rec.data;
   assign drop_cnt_o    = drop_cnt_q;

   always_comb begin
      sel_d      = sel_cur;
      lock_d     = lock_q;
      drop_cnt_d = drop_cnt_q;
      if (handshake)
         lock_d = 1'b0;
      else if (out_vld)
         lock_d = 1'b1;
      if (core_i.vld && drop && drop_cnt_q != '1)
         drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q      <= SEL_HI;
         lock_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         sel_q      <= sel_d;
         lock_q     <= lock_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule
